// File: rtl/reduce_tree_pipe.sv
// Pipelined AND/OR/XOR/ADD reduction tree over NUM_INPUT_DATA lanes, one register per level.
// Define REDUCE_TREE_COUNT_EN to add o_num_valid, the per-beat count of valid lanes.
module reduce_tree_pipe #(
    parameter int NUM_INPUT_DATA = 8,
    parameter int DATA_WIDTH     = 8
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     i_en,
    input  logic [1:0]                               i_mode,
    input  logic [NUM_INPUT_DATA-1:0]                i_valid,
    input  logic [NUM_INPUT_DATA*DATA_WIDTH-1:0]     i_data_bus,
`ifdef REDUCE_TREE_COUNT_EN
    output logic [$clog2(NUM_INPUT_DATA+1)-1:0]      o_num_valid,
`endif
    output logic                                     o_valid,
    output logic [DATA_WIDTH+$clog2(NUM_INPUT_DATA)-1:0] o_data_bus
);

    localparam int LEVELS    = (NUM_INPUT_DATA > 1) ? $clog2(NUM_INPUT_DATA) : 1;
    localparam int OUT_WIDTH = DATA_WIDTH + $clog2(NUM_INPUT_DATA);
    localparam int BUS_NODES = (NUM_INPUT_DATA + 1) / 2;
    localparam int BUS_W     = BUS_NODES * OUT_WIDTH;
    localparam int CNT_W     = $clog2(NUM_INPUT_DATA + 1);

    localparam logic [1:0] MODE_AND = 2'b00;
    localparam logic [1:0] MODE_OR  = 2'b01;
    localparam logic [1:0] MODE_XOR = 2'b10;

    // Every node is carried at OUT_WIDTH so ADD partial sums never truncate.
    function automatic logic [OUT_WIDTH-1:0] mask_lane(
        input logic [1:0]            mode,
        input logic                  vld,
        input logic [DATA_WIDTH-1:0] d
    );
        logic [OUT_WIDTH-1:0] r;
        r = '0;
        if (vld)
            r[DATA_WIDTH-1:0] = d;
        else if (mode == MODE_AND)
            r[DATA_WIDTH-1:0] = '1;
        return r;
    endfunction

    function automatic logic [OUT_WIDTH-1:0] combine(
        input logic [1:0]           mode,
        input logic [OUT_WIDTH-1:0] a,
        input logic [OUT_WIDTH-1:0] b
    );
        logic [OUT_WIDTH-1:0] r;
        case (mode)
            MODE_AND: r = a & b;
            MODE_OR:  r = a | b;
            MODE_XOR: r = a ^ b;
            default:  r = a + b;
        endcase
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] popcount(input logic [NUM_INPUT_DATA-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int k = 0; k < NUM_INPUT_DATA; k++)
            c = c + CNT_W'(v[k]);
        return c;
    endfunction

    logic             vld_q  [LEVELS];
    logic [1:0]       mode_q [LEVELS];
    logic [BUS_W-1:0] lvl_q  [LEVELS];
    logic [BUS_W-1:0] lvl_d  [LEVELS];
`ifdef REDUCE_TREE_COUNT_EN
    logic [CNT_W-1:0] num_q  [LEVELS];
`endif

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int CNT_IN = (NUM_INPUT_DATA + (1 << l) - 1) >> l;
        localparam int HALF   = (CNT_IN + 1) / 2;

        logic [OUT_WIDTH-1:0] in_w [2*HALF];
        logic                 vld_w;
        logic [1:0]           mode_w;
        logic [BUS_W-1:0]     nxt_w;

        if (l == 0) begin : g_src_in
            assign vld_w  = |i_valid;
            assign mode_w = i_mode;
            for (genvar j = 0; j < 2*HALF; j++) begin : g_lane
                if (j < NUM_INPUT_DATA) begin : g_live
                    assign in_w[j] = mask_lane(i_mode, i_valid[j],
                                               i_data_bus[j*DATA_WIDTH +: DATA_WIDTH]);
                end else begin : g_pad
                    assign in_w[j] = '0;
                end
            end
        end else begin : g_src_reg
            assign vld_w  = vld_q[l-1];
            assign mode_w = mode_q[l-1];
            for (genvar j = 0; j < 2*HALF; j++) begin : g_node
                if (j < CNT_IN) begin : g_live
                    assign in_w[j] = lvl_q[l-1][j*OUT_WIDTH +: OUT_WIDTH];
                end else begin : g_pad
                    assign in_w[j] = '0;
                end
            end
        end

        // Bubbles carry zero data so an invalid output is always all-zero.
        always_comb begin
            nxt_w = '0;
            if (vld_w) begin
                for (int j = 0; j < HALF; j++) begin
                    if (2*j + 1 < CNT_IN)
                        nxt_w[j*OUT_WIDTH +: OUT_WIDTH] = combine(mode_w, in_w[2*j], in_w[2*j+1]);
                    else
                        nxt_w[j*OUT_WIDTH +: OUT_WIDTH] = in_w[2*j];
                end
            end
        end

        assign lvl_d[l] = nxt_w;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int l = 0; l < LEVELS; l++) begin
                vld_q[l]  <= 1'b0;
                mode_q[l] <= '0;
                lvl_q[l]  <= '0;
`ifdef REDUCE_TREE_COUNT_EN
                num_q[l]  <= '0;
`endif
            end
        end else if (i_en) begin
            vld_q[0]  <= |i_valid;
            mode_q[0] <= i_mode;
`ifdef REDUCE_TREE_COUNT_EN
            num_q[0]  <= popcount(i_valid);
`endif
            for (int l = 1; l < LEVELS; l++) begin
                vld_q[l]  <= vld_q[l-1];
                mode_q[l] <= mode_q[l-1];
`ifdef REDUCE_TREE_COUNT_EN
                num_q[l]  <= num_q[l-1];
`endif
            end
            for (int l = 0; l < LEVELS; l++)
                lvl_q[l] <= lvl_d[l];
        end
    end

    assign o_valid    = vld_q[LEVELS-1];
    assign o_data_bus = lvl_q[LEVELS-1][OUT_WIDTH-1:0];
`ifdef REDUCE_TREE_COUNT_EN
    assign o_num_valid = num_q[LEVELS-1];
`endif

endmodule

// File: tb/tb_reduce_tree_pipe.sv
// Table-driven and scoreboard bench for reduce_tree_pipe (8x8 main instance, 5x4 odd-lane instance).
module tb_reduce_tree_pipe;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_en;
    logic [1:0]  i_mode;
    logic [7:0]  i_valid;
    logic [63:0] i_data_bus;
    logic        o_valid;
    logic [10:0] o_data_bus;

    logic        o5_en;
    logic [1:0]  o5_mode;
    logic [4:0]  o5_valid;
    logic [19:0] o5_data;
    logic        o5_ovalid;
    logic [6:0]  o5_odata;
`ifdef REDUCE_TREE_COUNT_EN
    logic [3:0]  o_num_valid;
    logic [2:0]  o5_num;
`endif

    always #5 clk = ~clk;

    reduce_tree_pipe #(.NUM_INPUT_DATA(8), .DATA_WIDTH(8)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .i_en       (i_en),
        .i_mode     (i_mode),
        .i_valid    (i_valid),
        .i_data_bus (i_data_bus),
`ifdef REDUCE_TREE_COUNT_EN
        .o_num_valid(o_num_valid),
`endif
        .o_valid    (o_valid),
        .o_data_bus (o_data_bus)
    );

    reduce_tree_pipe #(.NUM_INPUT_DATA(5), .DATA_WIDTH(4)) u_odd (
        .clk        (clk),
        .rst        (rst),
        .i_en       (o5_en),
        .i_mode     (o5_mode),
        .i_valid    (o5_valid),
        .i_data_bus (o5_data),
`ifdef REDUCE_TREE_COUNT_EN
        .o_num_valid(o5_num),
`endif
        .o_valid    (o5_ovalid),
        .o_data_bus (o5_odata)
    );

    typedef struct {
        logic [10:0] data;
        logic [3:0]  cnt;
        int          due;
    } exp_t;

    typedef struct {
        logic [1:0]  mode;
        logic [7:0]  valid;
        logic [63:0] data;
        logic [10:0] exp;
    } vec_t;

    exp_t        sb[$];
    vec_t        vecs[11];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          en_cnt   = 0;
    logic        exp_vld  = 1'b0;
    logic [10:0] exp_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Serial fold over the lanes, independent of any tree ordering.
    function automatic logic [10:0] ref_reduce(input logic [1:0] m, input logic [7:0] v,
                                               input logic [63:0] d);
        logic [10:0] acc;
        logic [10:0] lane;
        acc = (m == 2'b00) ? 11'h0FF : 11'h000;
        for (int k = 0; k < 8; k++) begin
            if (v[k]) begin
                lane = {3'b000, d[8*k +: 8]};
                case (m)
                    2'b00:   acc = acc & lane;
                    2'b01:   acc = acc | lane;
                    2'b10:   acc = acc ^ lane;
                    default: acc = acc + lane;
                endcase
            end
        end
        return acc;
    endfunction

    task automatic step(input logic r, input logic en, input logic [1:0] m, input logic [7:0] v,
                        input logic [63:0] d, input logic [10:0] ex);
        exp_t e;
        rst = r; i_en = en; i_mode = m; i_valid = v; i_data_bus = d;
        if (!r && en && (v != 8'h00)) begin
            e.data = ex;
            e.cnt  = 4'($countones(v));
            e.due  = en_cnt + LAT;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (r) begin
            sb.delete();
            exp_vld = 1'b0; exp_data = '0;
            check("reset_valid", 32'(o_valid), 32'd0);
            check("reset_data", 32'(o_data_bus), 32'd0);
            check("odd_reset_valid", 32'(o5_ovalid), 32'd0);
            check("odd_reset_data", 32'(o5_odata), 32'd0);
`ifdef REDUCE_TREE_COUNT_EN
            check("reset_num", 32'(o_num_valid), 32'd0);
`endif
        end else if (!en) begin
            check("stall_valid", 32'(o_valid), 32'(exp_vld));
            check("stall_data", 32'(o_data_bus), 32'(exp_data));
        end else begin
            en_cnt++;
            if (sb.size() > 0 && sb[0].due == en_cnt) begin
                e = sb.pop_front();
                exp_vld = 1'b1; exp_data = e.data;
                check("out_valid", 32'(o_valid), 32'd1);
                check("out_data", 32'(o_data_bus), 32'(e.data));
`ifdef REDUCE_TREE_COUNT_EN
                check("out_num", 32'(o_num_valid), 32'(e.cnt));
`endif
            end else begin
                exp_vld = 1'b0; exp_data = '0;
                check("idle_valid", 32'(o_valid), 32'd0);
                check("idle_data", 32'(o_data_bus), 32'd0);
`ifdef REDUCE_TREE_COUNT_EN
                check("idle_num", 32'(o_num_valid), 32'd0);
`endif
            end
        end
    endtask

    task automatic bubbles(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b1, 2'b01, 8'h00, 64'h0, 11'h0);
    endtask

    initial begin
        vecs[0]  = '{2'b01, 8'hFF, 64'h8040201008040201, 11'h0FF};
        vecs[1]  = '{2'b00, 8'hFF, 64'hF0F0F0F0F0F0F0F0, 11'h0F0};
        vecs[2]  = '{2'b10, 8'hFF, 64'hF0F0F0F0F0F0F0F0, 11'h000};
        vecs[3]  = '{2'b11, 8'hFF, 64'hF0F0F0F0F0F0F0F0, 11'h780};
        vecs[4]  = '{2'b00, 8'hF7, 64'h0F0F0F0F000F0F0F, 11'h00F};
        vecs[5]  = '{2'b00, 8'hFF, 64'h0F0F0F0F000F0F0F, 11'h000};
        vecs[6]  = '{2'b11, 8'hFF, 64'hFFFFFFFFFFFFFFFF, 11'h7F8};
        vecs[7]  = '{2'b11, 8'h01, 64'hFFFFFFFFFFFFFF12, 11'h012};
        vecs[8]  = '{2'b10, 8'h0F, 64'h8040201008040201, 11'h00F};
        vecs[9]  = '{2'b00, 8'h80, 64'h5A00000000000000, 11'h05A};
        vecs[10] = '{2'b01, 8'hA6, 64'h1122334455667788, 11'h077};

        rst = 1'b1; i_en = 1'b0; i_mode = '0; i_valid = '0; i_data_bus = '0;
        o5_en = 1'b0; o5_mode = '0; o5_valid = '0; o5_data = '0;

        step(1'b1, 1'b0, 2'b00, 8'h00, 64'h0, 11'h0);
        step(1'b1, 1'b0, 2'b00, 8'h00, 64'h0, 11'h0);

        for (int i = 0; i < 11; i++)
            step(1'b0, 1'b1, vecs[i].mode, vecs[i].valid, vecs[i].data, vecs[i].exp);
        bubbles(4);

        // Three beats in flight, then a 4-cycle stall holding the oldest one on the output.
        step(1'b0, 1'b1, 2'b11, 8'hFF, 64'h0102030405060708, 11'h024);
        step(1'b0, 1'b1, 2'b01, 8'h3C, 64'h0000A0B0C0D00000, 11'h0F0);
        step(1'b0, 1'b1, 2'b10, 8'h81, 64'h5500000000000033, 11'h066);
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b0, 2'b11, 8'hFF, 64'hFFFFFFFFFFFFFFFF, 11'h0);
        bubbles(4);

        for (int i = 0; i < 40; i++) begin
            logic        en;
            logic [1:0]  m;
            logic [7:0]  v;
            logic [63:0] d;
            en = ($urandom_range(0, 3) != 0);
            m  = 2'($urandom_range(0, 3));
            v  = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            d  = {$urandom, $urandom};
            step(1'b0, en, m, v, d, ref_reduce(m, v, d));
        end
        bubbles(4);

        // Reset while three beats are in flight: none may reach the output.
        step(1'b0, 1'b1, 2'b11, 8'hFF, 64'h1111111111111111, 11'h088);
        step(1'b0, 1'b1, 2'b01, 8'hFF, 64'h0000000000000001, 11'h001);
        step(1'b0, 1'b1, 2'b00, 8'h01, 64'h00000000000000AA, 11'h0AA);
        step(1'b1, 1'b1, 2'b01, 8'hFF, 64'h00000000000000FF, 11'h0);
        bubbles(5);

        o5_en = 1'b1; o5_mode = 2'b11; o5_valid = 5'h1F; o5_data = 20'hFFFFF;
        bubbles(1);
        o5_valid = 5'h00;
        bubbles(2);
        check("odd_add_valid", 32'(o5_ovalid), 32'd1);
        check("odd_add_data", 32'(o5_odata), 32'd75);
`ifdef REDUCE_TREE_COUNT_EN
        check("odd_add_num", 32'(o5_num), 32'd5);
`endif
        bubbles(1);
        check("odd_after_valid", 32'(o5_ovalid), 32'd0);
        check("odd_after_data", 32'(o5_odata), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
